// File: rtl/ula_seq.sv
// Registered ALU for the SAP-BR datapath: one op per start request, Z/C/N/V flag register, tri-state W-bus drive.
// Build option ULA_MUL_EN adds the multi-cycle shift-and-add multiplier (EXEC state); without it op 111 is a NOP.
module ula_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [2:0]       op,
   input  logic             start,
   input  logic             ALU_out,
   output logic [WIDTH-1:0] S,
   output logic             busy,
   output logic             done,
   output logic             flag_z,
   output logic             flag_c,
   output logic             flag_n,
   output logic             flag_v
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_NOT = 3'b101;
   localparam logic [2:0] OP_SHL = 3'b110;
   localparam logic [2:0] OP_MUL = 3'b111;
   localparam int MSB = WIDTH - 1;

`ifdef ULA_MUL_EN
   typedef enum logic [1:0] {ST_IDLE, ST_EXEC, ST_DONE} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_DONE} state_t;
`endif

   // Current state is kept as a named enum so checkers can bind to it.
   state_t state_q, state_d;

   logic [WIDTH-1:0] result_q;
   logic [WIDTH:0]   sum, diff;
   logic [WIDTH-1:0] alu_r;
   logic             alu_c, alu_v;
   logic             load_alu;

   assign sum  = {1'b0, A} + {1'b0, B};
   assign diff = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);

   always_comb begin
      alu_r = '0;
      alu_c = 1'b0;
      alu_v = 1'b0;
      case (op)
         OP_ADD: begin
            alu_r = sum[MSB:0];
            alu_c = sum[WIDTH];
            alu_v = (A[MSB] == B[MSB]) && (sum[MSB] != A[MSB]);
         end
         OP_SUB: begin
            alu_r = diff[MSB:0];
            alu_c = diff[WIDTH];
            alu_v = (A[MSB] != B[MSB]) && (diff[MSB] != A[MSB]);
         end
         OP_AND: alu_r = A & B;
         OP_OR:  alu_r = A | B;
         OP_XOR: alu_r = A ^ B;
         OP_NOT: alu_r = ~A;
         OP_SHL: begin
            alu_r = {A[MSB-1:0], 1'b0};
            alu_c = A[MSB];
         end
         default: ;
      endcase
   end

`ifdef ULA_MUL_EN
   localparam int CW = $clog2(WIDTH + 1);
   logic [CW-1:0]        cnt_q;
   logic [2*WIDTH-1:0]   mcand_q, acc_q, acc_nxt;
   logic [WIDTH-1:0]     mplier_q;
   logic                 mul_start, mul_step, mul_fin;

   // Final partial product is folded in combinationally on the last EXEC cycle.
   assign acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
      end else if (mul_start) begin
         cnt_q    <= CW'(WIDTH);
         mcand_q  <= {{WIDTH{1'b0}}, A};
         mplier_q <= B;
         acc_q    <= '0;
      end else if (mul_step) begin
         cnt_q    <= cnt_q - CW'(1);
         mcand_q  <= mcand_q << 1;
         mplier_q <= mplier_q >> 1;
         acc_q    <= acc_nxt;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      load_alu = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
`ifdef ULA_MUL_EN
      mul_start = 1'b0;
      mul_step  = 1'b0;
      mul_fin   = 1'b0;
`endif
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (op == OP_MUL) begin
`ifdef ULA_MUL_EN
                  mul_start = 1'b1;
                  state_d   = ST_EXEC;
`else
                  state_d   = ST_DONE;
`endif
               end else begin
                  load_alu = 1'b1;
                  state_d  = ST_DONE;
               end
            end
         end
`ifdef ULA_MUL_EN
         ST_EXEC: begin
            busy     = 1'b1;
            mul_step = 1'b1;
            if (cnt_q == CW'(1)) begin
               mul_fin = 1'b1;
               state_d = ST_DONE;
            end
         end
`endif
         ST_DONE: begin
            done    = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         result_q <= '0;
         flag_z   <= 1'b0;
         flag_c   <= 1'b0;
         flag_n   <= 1'b0;
         flag_v   <= 1'b0;
      end else if (load_alu) begin
         result_q <= alu_r;
         flag_z   <= (alu_r == '0);
         flag_c   <= alu_c;
         flag_n   <= alu_r[MSB];
         flag_v   <= alu_v;
`ifdef ULA_MUL_EN
      end else if (mul_fin) begin
         result_q <= acc_nxt[MSB:0];
         flag_z   <= (acc_nxt[MSB:0] == '0);
         flag_c   <= |acc_nxt[2*WIDTH-1:WIDTH];
         flag_n   <= acc_nxt[MSB];
         flag_v   <= |acc_nxt[2*WIDTH-1:WIDTH];
`endif
      end
   end

   assign S = ALU_out ? result_q : {WIDTH{1'bz}};

endmodule

// File: tb/tb_ula_seq.sv
// Self-checking bench for ula_seq (WIDTH=8): directed cases, randomized ops against an arithmetic reference model.
// Works with and without ULA_MUL_EN defined.
module tb_ula_seq;
   localparam int W = 8;
`ifdef ULA_MUL_EN
   localparam bit MUL_EN = 1'b1;
`else
   localparam bit MUL_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst;
   logic [W-1:0] a_in, b_in;
   logic [2:0]   op;
   logic         start, alu_out;
   wire  [W-1:0] s;
   logic         busy, done, fz, fc, fn, fv;

   logic [W-1:0] m_r;
   logic         m_z, m_c, m_n, m_v;
   logic [W-1:0] exp_q[$];
   int           n_cmp = 0;
   int           n_err = 0;

   always #5 clk = ~clk;

   // A released bus reads as all ones.
   for (genvar i = 0; i < W; i++) begin : g_pu
      pullup pu (s[i]);
   end

   ula_seq #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .A(a_in), .B(b_in), .op(op), .start(start),
      .ALU_out(alu_out), .S(s), .busy(busy), .done(done),
      .flag_z(fz), .flag_c(fc), .flag_n(fn), .flag_v(fv)
   );

   task automatic ref_model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
      int ua, ub, sa, sb, res;
      ua = int'(a);
      ub = int'(b);
      sa = (ua >= 128) ? ua - 256 : ua;
      sb = (ub >= 128) ? ub - 256 : ub;
      res = 0;
      if (o == 3'd7 && !MUL_EN) return;
      m_c = 1'b0;
      m_v = 1'b0;
      case (o)
         3'd0: begin res = ua + ub; m_c = (res > 255); m_v = ((sa + sb) > 127) || ((sa + sb) < -128); end
         3'd1: begin res = ua - ub; m_c = (ua >= ub); m_v = ((sa - sb) > 127) || ((sa - sb) < -128); end
         3'd2: res = ua & ub;
         3'd3: res = ua | ub;
         3'd4: res = ua ^ ub;
         3'd5: res = 255 - ua;
         3'd6: begin res = ua * 2; m_c = (ua >= 128); end
         default: begin res = ua * ub; m_c = (res > 255); m_v = m_c; end
      endcase
      m_r = res[W-1:0];
      m_z = (m_r == 0);
      m_n = m_r[W-1];
   endtask

   task automatic run_op(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit poke);
      logic [W-1:0] prev, exp_r;
      int lat, busy_cnt, exp_lat;
      prev = m_r;
      ref_model(o, a, b);
      exp_q.push_back(m_r);
      exp_lat = (o == 3'd7 && MUL_EN) ? W + 1 : 1;
      @(negedge clk);
      start = 1'b1; op = o; a_in = a; b_in = b;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busy_cnt = 0;
      while (done !== 1'b1 && lat < 3 * W) begin
         if (busy === 1'b1) busy_cnt++;
         n_cmp++;
         if (s !== prev) begin
            n_err++;
            $display("FAIL exec_bus op=%0d cycle=%0d: S=%h expected %h", o, lat, s, prev);
         end
         if (lat == 2 && poke) begin start = 1'b1; op = 3'd0; end
         else start = 1'b0;
         a_in = W'($urandom);
         b_in = W'($urandom);
         @(negedge clk);
         lat++;
      end
      start = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || lat != exp_lat) begin
         n_err++;
         $display("FAIL latency op=%0d: done=%b after %0d cycles, expected done at %0d", o, done, lat, exp_lat);
      end
      n_cmp++;
      if (busy !== 1'b0 || busy_cnt != exp_lat - 1) begin
         n_err++;
         $display("FAIL busy op=%0d: busy cycles %0d (busy now %b), expected %0d (busy now 0)", o, busy_cnt, busy, exp_lat - 1);
      end
      exp_r = exp_q.pop_front();
      n_cmp++;
      if (s !== exp_r) begin
         n_err++;
         $display("FAIL result op=%0d a=%h b=%h: S=%h expected %h", o, a, b, s, exp_r);
      end
      n_cmp++;
      if ({fz, fc, fn, fv} !== {m_z, m_c, m_n, m_v}) begin
         n_err++;
         $display("FAIL flags op=%0d a=%h b=%h: zcnv=%b%b%b%b expected %b%b%b%b", o, a, b, fz, fc, fn, fv, m_z, m_c, m_n, m_v);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || busy !== 1'b0 || s !== exp_r) begin
         n_err++;
         $display("FAIL after_done op=%0d: done=%b busy=%b S=%h expected 0 0 %h", o, done, busy, s, exp_r);
      end
      if (poke) begin
         @(negedge clk);
         n_cmp++;
         if (done !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_not_queued: done=%b busy=%b expected 0 0", done, busy);
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; alu_out = 1'b1; op = 3'd0; a_in = '0; b_in = '0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if (s !== 8'h00 || {fz, fc, fn, fv} !== 4'b0000 || busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL reset: S=%h zcnv=%b%b%b%b busy=%b done=%b expected 00 0000 0 0", s, fz, fc, fn, fv, busy, done);
      end
      rst = 1'b0;
      m_r = '0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_v = 1'b0;
   endtask

   task automatic test_directed();
      run_op(3'd0, 8'hF0, 8'h20, 1'b0);
      n_cmp++;
      if (s !== 8'h10 || {fz, fc, fn, fv} !== 4'b0100) begin
         n_err++;
         $display("FAIL add_f0_20: S=%h zcnv=%b%b%b%b expected 10 0100", s, fz, fc, fn, fv);
      end
      run_op(3'd1, 8'h05, 8'h05, 1'b0);
      n_cmp++;
      if (s !== 8'h00 || fz !== 1'b1 || fc !== 1'b1) begin
         n_err++;
         $display("FAIL sub_equal: S=%h z=%b c=%b expected 00 1 1", s, fz, fc);
      end
      run_op(3'd1, 8'h03, 8'h05, 1'b0);
      n_cmp++;
      if (s !== 8'hFE || fc !== 1'b0 || fn !== 1'b1) begin
         n_err++;
         $display("FAIL sub_borrow: S=%h c=%b n=%b expected fe 0 1", s, fc, fn);
      end
      run_op(3'd0, 8'h7F, 8'h01, 1'b0);
      n_cmp++;
      if (s !== 8'h80 || fv !== 1'b1 || fn !== 1'b1 || fc !== 1'b0) begin
         n_err++;
         $display("FAIL add_overflow: S=%h v=%b n=%b c=%b expected 80 1 1 0", s, fv, fn, fc);
      end
      run_op(3'd6, 8'h81, 8'h00, 1'b0);
      n_cmp++;
      if (s !== 8'h02 || fc !== 1'b1) begin
         n_err++;
         $display("FAIL shl_81: S=%h c=%b expected 02 1", s, fc);
      end
      for (int i = 2; i <= 5; i++) run_op(3'(i), 8'hA5, 8'h3C, 1'b0);
   endtask

`ifdef ULA_MUL_EN
   task automatic test_mul();
      run_op(3'd7, 8'h0C, 8'h0B, 1'b1);
      n_cmp++;
      if (s !== 8'h84 || fc !== 1'b0) begin
         n_err++;
         $display("FAIL mul_0c_0b: S=%h c=%b expected 84 0", s, fc);
      end
      run_op(3'd7, 8'h20, 8'h10, 1'b0);
      n_cmp++;
      if (s !== 8'h00 || {fz, fc, fv} !== 3'b111) begin
         n_err++;
         $display("FAIL mul_20_10: S=%h z=%b c=%b v=%b expected 00 1 1 1", s, fz, fc, fv);
      end
   endtask

   task automatic test_mul_reset();
      int done_seen;
      run_op(3'd0, 8'h11, 8'h22, 1'b0);
      @(negedge clk);
      start = 1'b1; op = 3'd7; a_in = 8'hFF; b_in = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      m_r = '0; m_z = 1'b0; m_c = 1'b0; m_n = 1'b0; m_v = 1'b0;
      n_cmp++;
      if (busy !== 1'b0 || done !== 1'b0 || s !== 8'h00 || {fz, fc, fn, fv} !== 4'b0000) begin
         n_err++;
         $display("FAIL mul_reset: busy=%b done=%b S=%h zcnv=%b%b%b%b expected 0 0 00 0000", busy, done, s, fz, fc, fn, fv);
      end
      done_seen = 0;
      for (int i = 0; i < W + 2; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      n_cmp++;
      if (done_seen != 0) begin
         n_err++;
         $display("FAIL mul_reset_quiet: done/busy seen %0d cycles, expected 0", done_seen);
      end
   endtask
`else
   task automatic test_nop();
      run_op(3'd0, 8'h7F, 8'h01, 1'b0);
      run_op(3'd7, 8'h0C, 8'h0B, 1'b1);
      n_cmp++;
      if (s !== 8'h80 || {fz, fc, fn, fv} !== 4'b0011) begin
         n_err++;
         $display("FAIL nop_hold: S=%h zcnv=%b%b%b%b expected 80 0011", s, fz, fc, fn, fv);
      end
   endtask
`endif

   task automatic test_bus();
      run_op(3'd2, 8'h3C, 8'hFF, 1'b0);
      alu_out = 1'b0;
      #1;
      n_cmp++;
      if (s !== 8'hFF) begin
         n_err++;
         $display("FAIL bus_release: S=%h expected ff (pulled up, undriven)", s);
      end
      alu_out = 1'b1;
      #1;
      n_cmp++;
      if (s !== 8'h3C) begin
         n_err++;
         $display("FAIL bus_drive: S=%h expected 3c", s);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 40; i++)
         run_op(3'($urandom_range(0, 7)), W'($urandom), W'($urandom), bit'($urandom_range(0, 1)));
   endtask

   initial begin
      test_reset();
      test_directed();
`ifdef ULA_MUL_EN
      test_mul();
      test_mul_reset();
`else
      test_nop();
`endif
      test_bus();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
